// File: rtl/vecmac_acc_sink.sv
// vecmac_acc_sink: accumulates cfg_len signed partial-sum beats into one dot-product result on a valid/ready register (VECMAC_ACC_SAT_EN adds saturating adds and err_sat)
module vecmac_acc_sink #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy,
  output logic             err_drop,
  input  logic             err_clr
`ifdef VECMAC_ACC_SAT_EN
  ,
  output logic             err_sat
`endif
);
  logic [LEN_W-1:0] cnt, len_q, cnt_nx, len_eff;
  logic [ACC_W-1:0] acc, sx, acc_nx;
  logic beat, first, last, load, drop;
  assign beat    = in_valid && !clear;
  assign first   = beat && cnt == '0;
  assign len_eff = first ? (cfg_len == '0 ? LEN_W'(1) : cfg_len) : len_q;
  assign cnt_nx  = cnt + LEN_W'(1);
  assign last    = beat && cnt_nx == len_eff;
  assign sx      = ACC_W'($signed(in_sum));
  assign load    = last && (!out_valid || out_ready);
  assign drop    = last && out_valid && !out_ready;
  assign busy    = cnt != '0;
`ifdef VECMAC_ACC_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           sat_hit;
  assign sum_w   = {acc[ACC_W-1], acc} + {sx[ACC_W-1], sx};
  assign sat_hit = beat && !first && sum_w[ACC_W] != sum_w[ACC_W-1];
  assign acc_nx  = first ? sx :
                   !sat_hit ? sum_w[ACC_W-1:0] :
                   sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  // sticky saturation flag; a new clamp wins over err_clr
  always_ff @(posedge clk)
    if (!rst_n) err_sat <= 1'b0;
    else err_sat <= sat_hit || (err_sat && !err_clr);
`else
  assign acc_nx = first ? sx : acc + sx;
`endif
  // frame state: beat counter, running sum, and the length latched on the first beat
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      len_q <= LEN_W'(1);
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_valid) begin
      acc <= acc_nx;
      cnt <= last ? '0 : cnt_nx;
      if (first) len_q <= len_eff;
    end
  // result holding register with sticky drop flag when a result finds it occupied
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      err_drop  <= 1'b0;
    end else begin
      out_valid <= load || (out_valid && !out_ready);
      if (load) out_acc <= acc_nx;
      err_drop  <= drop || (err_drop && !err_clr);
    end
endmodule

// File: tb/tb_vecmac_acc_sink.sv
// tb_vecmac_acc_sink: directed checks of the accumulating result sink (32-bit and 18-bit accumulator instances)
module tb_vecmac_acc_sink;
  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready, err_clr;
  logic [15:0] cfg_len;
  logic [17:0] in_sum;
  logic        out_valid, busy, err_drop, n_out_valid, n_busy, n_err_drop;
  logic [31:0] out_acc;
  logic [17:0] n_out_acc;
  int          asserts = 0, failures = 0;
`ifdef VECMAC_ACC_SAT_EN
  logic        err_sat, n_err_sat;
  localparam logic [17:0] N_EXP = 18'h1FFFF;
`else
  localparam logic [17:0] N_EXP = 18'h3FFFE;
`endif

  always #5 clk = ~clk;

  vecmac_acc_sink u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .clear(clear), .in_valid(in_valid),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .busy(busy), .err_drop(err_drop), .err_clr(err_clr)
`ifdef VECMAC_ACC_SAT_EN
    , .err_sat(err_sat)
`endif
  );

  vecmac_acc_sink #(.ACC_W(18)) u_narrow (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .clear(clear), .in_valid(in_valid),
    .in_sum(in_sum), .out_valid(n_out_valid), .out_ready(out_ready), .out_acc(n_out_acc),
    .busy(n_busy), .err_drop(n_err_drop), .err_clr(err_clr)
`ifdef VECMAC_ACC_SAT_EN
    , .err_sat(n_err_sat)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    cfg_len = 16'd1; in_sum = '0;
    @(negedge clk); @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    asserts++; if (out_acc !== 32'd0) begin failures++; $display("FAIL reset_out_acc: got %h expected 0", out_acc); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    asserts++; if (err_drop !== 1'b0) begin failures++; $display("FAIL reset_err_drop: got %b expected 0", err_drop); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    @(negedge clk);
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_beat1: got %b expected 0", busy); end
    cfg_len = 16'd4; out_ready = 1'b1; in_valid = 1'b1; in_sum = 18'd100;
    @(negedge clk);
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_beat2: got %b expected 1", busy); end
    in_sum = 18'h3FFFD;
    @(negedge clk);
    in_sum = 18'd7;
    @(negedge clk);
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_beat4: got %b expected 1", busy); end
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    in_sum = 18'd0;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    asserts++; if (out_acc !== 32'd104) begin failures++; $display("FAIL basic_acc: got %h expected %h", out_acc, 32'd104); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    in_valid = 1'b0;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed: got %b expected 0", out_valid); end
    asserts++; if (out_acc !== 32'd104) begin failures++; $display("FAIL basic_acc_hold: got %h expected %h", out_acc, 32'd104); end
  endtask

  task automatic test_len0;
    @(negedge clk);
    cfg_len = 16'd0; in_valid = 1'b1; in_sum = 18'h20000;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL len0_valid: got %b expected 1", out_valid); end
    asserts++; if (out_acc !== 32'hFFFE0000) begin failures++; $display("FAIL len0_acc: got %h expected fffe0000", out_acc); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy: got %b expected 0", busy); end
    in_valid = 1'b0;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL len0_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_cfg_hold;
    @(negedge clk);
    cfg_len = 16'd3; in_valid = 1'b1; in_sum = 18'd10;
    @(negedge clk);
    cfg_len = 16'd1; in_sum = 18'd20;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cfg_hold_early: got %b expected 0", out_valid); end
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL cfg_hold_busy: got %b expected 1", busy); end
    in_sum = 18'd30;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cfg_hold_valid: got %b expected 1", out_valid); end
    asserts++; if (out_acc !== 32'd60) begin failures++; $display("FAIL cfg_hold_acc: got %h expected %h", out_acc, 32'd60); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cfg_len = 16'd2; out_ready = 1'b1; in_valid = 1'b1; in_sum = 18'd1;
    @(negedge clk);
    in_sum = 18'd2;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd3) begin failures++; $display("FAIL b2b_first: got v=%b acc=%h expected v=1 acc=3", out_valid, out_acc); end
    in_sum = 18'd3;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: got %b expected 0", out_valid); end
    in_sum = 18'd4;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd7) begin failures++; $display("FAIL b2b_second: got v=%b acc=%h expected v=1 acc=7", out_valid, out_acc); end
    cfg_len = 16'd1; in_sum = 18'd5;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd5) begin failures++; $display("FAIL b2b_len1_a: got v=%b acc=%h expected v=1 acc=5", out_valid, out_acc); end
    in_sum = 18'd6;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd6) begin failures++; $display("FAIL b2b_len1_b: got v=%b acc=%h expected v=1 acc=6", out_valid, out_acc); end
    in_sum = 18'd7;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd7) begin failures++; $display("FAIL b2b_len1_c: got v=%b acc=%h expected v=1 acc=7", out_valid, out_acc); end
    in_valid = 1'b0;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_clear;
    @(negedge clk);
    cfg_len = 16'd3; out_ready = 1'b1; in_valid = 1'b1; in_sum = 18'd5;
    @(negedge clk);
    in_sum = 18'd6;
    @(negedge clk);
    in_sum = 18'd9; clear = 1'b1;
    @(negedge clk);
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy: got %b expected 0", busy); end
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clear_no_result: got %b expected 0", out_valid); end
    clear = 1'b0; in_sum = 18'd1;
    @(negedge clk);
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_restart_busy: got %b expected 1", busy); end
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clear_early: got %b expected 0", out_valid); end
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd3) begin failures++; $display("FAIL clear_result: got v=%b acc=%h expected v=1 acc=3", out_valid, out_acc); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop;
    @(negedge clk);
    cfg_len = 16'd2; out_ready = 1'b0; in_valid = 1'b1; in_sum = 18'd1;
    @(negedge clk);
    in_sum = 18'd2;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd3) begin failures++; $display("FAIL drop_first: got v=%b acc=%h expected v=1 acc=3", out_valid, out_acc); end
    in_sum = 18'd3;
    @(negedge clk);
    in_sum = 18'd4;
    @(negedge clk);
    asserts++; if (out_acc !== 32'd3) begin failures++; $display("FAIL drop_hold: got %h expected 3", out_acc); end
    asserts++; if (err_drop !== 1'b1) begin failures++; $display("FAIL drop_flag: got %b expected 1", err_drop); end
    in_sum = 18'd5;
    @(negedge clk);
    in_sum = 18'd6; err_clr = 1'b1;
    @(negedge clk);
    asserts++; if (err_drop !== 1'b1) begin failures++; $display("FAIL drop_set_wins: got %b expected 1", err_drop); end
    asserts++; if (out_acc !== 32'd3) begin failures++; $display("FAIL drop_hold2: got %h expected 3", out_acc); end
    in_valid = 1'b0;
    @(negedge clk);
    asserts++; if (err_drop !== 1'b0) begin failures++; $display("FAIL drop_clr: got %b expected 0", err_drop); end
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drop_still_valid: got %b expected 1", out_valid); end
    err_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_narrow;
`ifdef VECMAC_ACC_SAT_EN
    asserts++; if (n_err_sat !== 1'b0) begin failures++; $display("FAIL sat_idle: got %b expected 0", n_err_sat); end
`endif
    @(negedge clk);
    cfg_len = 16'd2; out_ready = 1'b1; in_valid = 1'b1; in_sum = 18'h1FFFF;
    @(negedge clk);
    @(negedge clk);
    asserts++; if (out_acc !== 32'h0003FFFE) begin failures++; $display("FAIL wide_sum: got %h expected 0003fffe", out_acc); end
    asserts++; if (n_out_valid !== 1'b1 || n_out_acc !== N_EXP) begin failures++; $display("FAIL narrow_sum: got v=%b acc=%h expected v=1 acc=%h", n_out_valid, n_out_acc, N_EXP); end
`ifdef VECMAC_ACC_SAT_EN
    asserts++; if (n_err_sat !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b expected 1", n_err_sat); end
    asserts++; if (err_sat !== 1'b0) begin failures++; $display("FAIL sat_wide_flag: got %b expected 0", err_sat); end
`endif
    in_valid = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
`ifdef VECMAC_ACC_SAT_EN
    asserts++; if (n_err_sat !== 1'b0) begin failures++; $display("FAIL sat_clr: got %b expected 0", n_err_sat); end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cfg_len = 16'd1; out_ready = 1'b0; in_valid = 1'b1; in_sum = 18'd42;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b1 || out_acc !== 32'd42) begin failures++; $display("FAIL rst_mid_held: got v=%b acc=%h expected v=1 acc=2a", out_valid, out_acc); end
    cfg_len = 16'd3; in_sum = 18'd1;
    @(negedge clk);
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    asserts++; if (out_valid !== 1'b0 || out_acc !== 32'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_state: got v=%b acc=%h busy=%b expected v=0 acc=0 busy=0", out_valid, out_acc, busy); end
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_len0;
    test_cfg_hold;
    test_back_to_back;
    test_clear;
    test_drop;
    test_narrow;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
